// File: rtl/int_service_sequencer_pkg.sv
// Shared constants and types for the 8051 interrupt service sequencer.
package int_pkg;

  localparam int unsigned NSRC = 5;

  // Source index order matches the vector table order.
  localparam int unsigned SRC_EX0 = 0;
  localparam int unsigned SRC_ET0 = 1;
  localparam int unsigned SRC_EX1 = 2;
  localparam int unsigned SRC_ET1 = 3;
  localparam int unsigned SRC_ES  = 4;

  localparam logic [15:0] VEC_BASE_DFLT   = 16'h0003;
  localparam int unsigned VEC_STRIDE_DFLT = 8;

  typedef enum logic {
    IDLE,
    CALL
  } state_t;

endpackage

// File: rtl/int_service_sequencer_if.sv
// Vectored-call handshake between the sequencer and the core control unit.
interface int_service_sequencer_if;

  logic        call_req;
  logic [15:0] call_vec;
  logic        call_ack;

  modport master (output call_req, output call_vec, input call_ack);
  modport slave  (input call_req, input call_vec, output call_ack);

endinterface

// File: rtl/int_service_sequencer_prio_pick.sv
// Two-level priority pick: lowest index wins within a level, high level
// only if no high service is active, low level only if nothing is active.
module int_prio_pick
  import int_pkg::*;
(
  input  logic [NSRC-1:0] cand,
  input  logic [NSRC-1:0] ip,
  input  logic [1:0]      in_svc,
  output logic            valid,
  output logic [2:0]      idx,
  output logic            level
);

  logic [NSRC-1:0] hi;
  logic [NSRC-1:0] lo;

  // Select the winning source and its level.
  always_comb begin
    hi    = cand & ip;
    lo    = cand & ~ip;
    valid = 1'b0;
    idx   = '0;
    level = 1'b0;
    if (hi != '0 && !in_svc[1]) begin
      valid = 1'b1;
      level = 1'b1;
      for (int unsigned i = NSRC; i > 0; i--) begin
        if (hi[i-1]) idx = 3'(i - 1);
      end
    end else if (lo != '0 && in_svc == 2'b00) begin
      valid = 1'b1;
      for (int unsigned i = NSRC; i > 0; i--) begin
        if (lo[i-1]) idx = 3'(i - 1);
      end
    end
  end

endmodule

// File: rtl/int_service_sequencer.sv
// Interrupt service sequencer: arbitrates at instruction boundaries, issues
// a vectored call, tracks in-service levels and strobes TCON flag clears.
module int_service_sequencer
  import int_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DFLT,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DFLT
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       int_req,
  input  logic                  ea,
  input  logic [NSRC-1:0]       ip,
  input  logic                  it0,
  input  logic                  it1,
  input  logic                  instr_end,
  input  logic                  blk_instr,
  input  logic                  reti,
  int_service_sequencer_if.master call_if,
  output logic [3:0]            clr_flag,
  output logic [1:0]            in_svc
);

  localparam logic [15:0] STRIDE16 = 16'(VEC_STRIDE);

  state_t          state_q, state_d;
  logic            call_req_q, call_req_d;
  logic [15:0]     call_vec_q, call_vec_d;
  logic [3:0]      clr_q, clr_d;
  logic [1:0]      in_svc_q, in_svc_d, svc_after_reti;
  logic [2:0]      idx_q, idx_d;
  logic            level_q, level_d;
  logic [NSRC-1:0] cand;
  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic            pick_level;

  assign cand = int_req & {NSRC{ea}};

  int_prio_pick u_pick (
    .cand   (cand),
    .ip     (ip),
    .in_svc (in_svc_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .level  (pick_level)
  );

  // Next-state, call handshake, in-service and strobe logic.
  always_comb begin
    state_d    = state_q;
    call_req_d = call_req_q;
    call_vec_d = call_vec_q;
    idx_d      = idx_q;
    level_d    = level_q;
    clr_d      = '0;

    // RETI unwinds the pre-edge level first; an acknowledge in the same
    // cycle then sets its own level on top of that result.
    svc_after_reti = in_svc_q;
    if (reti) begin
      if (in_svc_q[1]) svc_after_reti[1] = 1'b0;
      else             svc_after_reti[0] = 1'b0;
    end
    in_svc_d = svc_after_reti;

    unique case (state_q)
      IDLE: begin
        if (instr_end && !blk_instr && pick_valid) begin
          state_d    = CALL;
          call_req_d = 1'b1;
          call_vec_d = VEC_BASE + STRIDE16 * {13'b0, pick_idx};
          idx_d      = pick_idx;
          level_d    = pick_level;
        end
      end
      CALL: begin
        if (call_if.call_ack) begin
          state_d    = IDLE;
          call_req_d = 1'b0;
          if (level_q) in_svc_d[1] = 1'b1;
          else         in_svc_d[0] = 1'b1;
          case (idx_q)
            3'(SRC_EX0): clr_d[0] = it0;
            3'(SRC_ET0): clr_d[1] = 1'b1;
            3'(SRC_EX1): clr_d[2] = it1;
            3'(SRC_ET1): clr_d[3] = 1'b1;
            default:     clr_d    = '0;
          endcase
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      call_req_q <= 1'b0;
      call_vec_q <= '0;
      clr_q      <= '0;
      in_svc_q   <= '0;
      idx_q      <= '0;
      level_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      call_req_q <= call_req_d;
      call_vec_q <= call_vec_d;
      clr_q      <= clr_d;
      in_svc_q   <= in_svc_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
    end
  end

  assign call_if.call_req = call_req_q;
  assign call_if.call_vec = call_vec_q;
  assign clr_flag         = clr_q;
  assign in_svc           = in_svc_q;

endmodule
